rib_timer: RTL and testbench

//  Memory-mapped timer peripheral on the RIB bus: a responder for core load/store requests.

---
 rtl/rib_timer_pkg.sv | 28 ++
 rtl/rib_timer_core.sv | 100 ++++++++++
 rtl/rib_timer.sv | 167 ++++++++++++++++
 tb/tb_rib_timer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rib_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rib_timer_pkg
//  Description : Shared definitions for the RIB timer peripheral: register
//                offsets (addr[3:2]), CTRL bit indices and read-FSM state
//                encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package rib_timer_pkg;

    // Register offsets as decoded from addr[3:2]
    localparam logic [1:0] TIMER_CTRL  = 2'd0;
    localparam logic [1:0] TIMER_COUNT = 2'd1;
    localparam logic [1:0] TIMER_CMP   = 2'd2;
    localparam logic [1:0] TIMER_PRESC = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEND = 2;
    localparam int CTRL_ARL  = 3;

    // Read FSM states
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DONE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rib_timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : rib_timer_core
//  Description : Counting engine of the RIB timer. Owns the prescale counter,
//                the 32-bit COUNT register, the compare match, the sticky
//                pend bit and the enable bit (which a one-shot match clears).
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                i_wr_ctrl       - CTRL write strobe this cycle
//                i_wr_count      - COUNT write strobe this cycle
//                i_wr_presc      - PRESC write strobe this cycle
//                i_wr_data       - write data
//                i_arl           - auto-reload bit from CTRL
//                i_cmp, i_presc  - compare value and prescale divisor
//                o_en, o_pend    - CTRL.en and CTRL.pend
//                o_count         - current COUNT value
//  Revision    : 1.0 - initial release
// ============================================================================
module rib_timer_core
    import rib_timer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_ctrl,
    input  logic               i_wr_count,
    input  logic               i_wr_presc,
    input  logic [DATA_W-1:0]  i_wr_data,
    input  logic               i_arl,
    input  logic [DATA_W-1:0]  i_cmp,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_en,
    output logic               o_pend,
    output logic [DATA_W-1:0]  o_count
);

    localparam logic [PRESC_W-1:0] c_PC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]  c_CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] r_pc;
    logic [DATA_W-1:0]  r_count;
    logic               r_en;
    logic               r_pend;

    logic w_tick;
    logic w_match;
    logic w_en_rise;

    assign w_tick    = r_en && (r_pc == i_presc);
    // Match is judged on the pre-write COUNT, so a same-cycle COUNT write
    // cannot hide a match that the tick already produced.
    assign w_match   = w_tick && (r_count == i_cmp);
    assign w_en_rise = i_wr_ctrl && i_wr_data[CTRL_EN] && !r_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_count <= '0;
            r_en    <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            if (w_en_rise) begin
                r_pc <= '0;
            end else if (r_en) begin
                r_pc <= w_tick ? '0 : (r_pc + c_PC_ONE);
            end

            // Software COUNT write beats the hardware update; a PRESC write
            // in a tick cycle drops that tick's increment.
            if (i_wr_count) begin
                r_count <= i_wr_data;
            end else if (w_match) begin
                r_count <= '0;
            end else if (w_tick && !i_wr_presc) begin
                r_count <= r_count + c_CNT_ONE;
            end

            // Hardware set wins over a same-cycle write-1-to-clear.
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (i_wr_ctrl && i_wr_data[CTRL_PEND]) begin
                r_pend <= 1'b0;
            end

            // Software enable value wins over the one-shot auto-clear.
            if (i_wr_ctrl) begin
                r_en <= i_wr_data[CTRL_EN];
            end else if (w_match && !i_arl) begin
                r_en <= 1'b0;
            end
        end
    end

    assign o_en    = r_en;
    assign o_pend  = r_pend;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/rib_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rib_timer
//  Description : Memory-mapped timer responder on the RIB bus. Holds the
//                register file (CTRL.ie/arl, CMP, PRESC), the write decode and
//                the read FSM that stalls the core for one cycle per distinct
//                read. Counting lives in rib_timer_core.
//  Ports       : clk, rst                 - clock / sync active-high reset
//                wr_req_i, wr_en_i        - write request and qualifier
//                wr_addr_i, wr_data_i     - write address / data
//                rd_req_i, rd_addr_i      - read request / address
//                rd_data_o                - registered read data
//                hold_o                   - combinational pipeline hold
//                int_flag_o               - level interrupt (pend & ie)
//  Revision    : 1.0 - initial release
// ============================================================================
module rib_timer
    import rib_timer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              hold_o,
    output logic              int_flag_o
);

    logic               r_ie;
    logic               r_arl;
    logic [DATA_W-1:0]  r_cmp;
    logic [PRESC_W-1:0] r_presc;
    logic [DATA_W-1:0]  r_rd_data;
    logic [0:0]         r_rd_state;
    logic [1:0]         r_addr_q;

    logic [0:0]         w_rd_state_nxt;
    logic               w_hold;
    logic               w_wr;
    logic [1:0]         w_wr_idx;
    logic [1:0]         w_rd_idx;
    logic               w_wr_ctrl;
    logic               w_wr_count;
    logic               w_wr_cmp;
    logic               w_wr_presc;
    logic               w_en;
    logic               w_pend;
    logic [DATA_W-1:0]  w_count;
    logic [DATA_W-1:0]  w_rd_mux;
    logic               w_unused_addr;

    assign w_wr_idx   = wr_addr_i[3:2];
    assign w_rd_idx   = rd_addr_i[3:2];
    assign w_wr       = wr_req_i && wr_en_i;
    assign w_wr_ctrl  = w_wr && (w_wr_idx == TIMER_CTRL);
    assign w_wr_count = w_wr && (w_wr_idx == TIMER_COUNT);
    assign w_wr_cmp   = w_wr && (w_wr_idx == TIMER_CMP);
    assign w_wr_presc = w_wr && (w_wr_idx == TIMER_PRESC);

    assign w_unused_addr = ^{wr_addr_i[ADDR_W-1:4], wr_addr_i[1:0],
                             rd_addr_i[ADDR_W-1:4], rd_addr_i[1:0]};

    rib_timer_core #(
        .DATA_W  (DATA_W),
        .PRESC_W (PRESC_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_wr_ctrl  (w_wr_ctrl),
        .i_wr_count (w_wr_count),
        .i_wr_presc (w_wr_presc),
        .i_wr_data  (wr_data_i),
        .i_arl      (r_arl),
        .i_cmp      (r_cmp),
        .i_presc    (r_presc),
        .o_en       (w_en),
        .o_pend     (w_pend),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie    <= 1'b0;
            r_arl   <= 1'b0;
            r_cmp   <= '0;
            r_presc <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ie  <= wr_data_i[CTRL_IE];
                r_arl <= wr_data_i[CTRL_ARL];
            end
            if (w_wr_cmp) begin
                r_cmp <= wr_data_i;
            end
            if (w_wr_presc) begin
                r_presc <= wr_data_i[PRESC_W-1:0];
            end
        end
    end

    // Read mux sees the pre-write register values.
    always_comb begin
        w_rd_mux = '0;
        case (w_rd_idx)
            TIMER_CTRL:  w_rd_mux = {{(DATA_W-4){1'b0}}, r_arl, w_pend, r_ie, w_en};
            TIMER_COUNT: w_rd_mux = w_count;
            TIMER_CMP:   w_rd_mux = r_cmp;
            TIMER_PRESC: w_rd_mux = {{(DATA_W-PRESC_W){1'b0}}, r_presc};
            default:     w_rd_mux = '0;
        endcase
    end

    // Read FSM: a new address (or a read from IDLE) costs one hold cycle in
    // which the data is captured; a repeated address in DONE is free.
    always_comb begin
        w_hold         = 1'b0;
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (rd_req_i) begin
                    w_hold         = 1'b1;
                    w_rd_state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                if (!rd_req_i) begin
                    w_rd_state_nxt = RD_IDLE;
                end else if (w_rd_idx != r_addr_q) begin
                    w_hold = 1'b1;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
        // Reset aborts any in-flight read immediately.
        if (rst) begin
            w_hold = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_addr_q   <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_hold) begin
                r_rd_data <= w_rd_mux;
                r_addr_q  <= w_rd_idx;
            end
        end
    end

    assign rd_data_o  = r_rd_data;
    assign hold_o     = w_hold;
    assign int_flag_o = w_pend && r_ie;

endmodule
`default_nettype wire

// File: tb/tb_rib_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rib_timer
//  Description : Self-checking bench for rib_timer. A cycle-level reference
//                model of the timer registers and of the read handshake
//                predicts hold_o, rd_data_o and int_flag_o every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req_i;
    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic        rd_req_i;
    logic [31:0] rd_addr_i;
    logic [31:0] rd_data_o;
    logic        hold_o;
    logic        int_flag_o;

    always #5 clk = ~clk;

    rib_timer #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .PRESC_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req_i   (wr_req_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_req_i   (rd_req_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .hold_o     (hold_o),
        .int_flag_o (int_flag_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        m_en, m_ie, m_pend, m_arl;
    logic [31:0] m_count, m_cmp;
    logic [15:0] m_presc, m_pc;
    logic [31:0] m_rd_data;
    logic        m_prev_req;
    logic [1:0]  m_prev_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    return {28'd0, m_arl, m_pend, m_ie, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {16'd0, m_presc};
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_pend = 0; m_arl = 0;
        m_count = 0; m_cmp = 0; m_presc = 0; m_pc = 0;
        m_rd_data = 0; m_prev_req = 0; m_prev_addr = 0;
    endtask

    // One bus cycle: drive, check hold before the edge, advance the model at
    // the edge, check registered outputs just after it.
    task automatic step(input logic do_rst, input logic wr, input logic wen,
                        input logic [1:0] waddr, input logic [31:0] wdata,
                        input logic rd, input logic [1:0] raddr);
        logic [31:0] junk_w, junk_r;
        logic        exp_hold, tick, match, wc;
        junk_w    = $urandom();
        junk_r    = $urandom();
        rst       = do_rst;
        wr_req_i  = wr;
        wr_en_i   = wen;
        wr_addr_i = {junk_w[31:4], waddr, junk_w[1:0]};
        wr_data_i = wdata;
        rd_req_i  = rd;
        rd_addr_i = {junk_r[31:4], raddr, junk_r[1:0]};
        #3;
        exp_hold = rd && !(m_prev_req && (m_prev_addr == raddr));
        if (!do_rst) check_eq("hold", {31'd0, hold_o}, {31'd0, exp_hold});
        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else begin
            if (exp_hold) m_rd_data = model_reg(raddr);
            m_prev_req  = rd;
            m_prev_addr = raddr;
            wc    = wr && wen;
            tick  = m_en && (m_pc == m_presc);
            match = tick && (m_count == m_cmp);
            if (wc && waddr == 2'd0 && wdata[0] && !m_en) m_pc = 0;
            else if (m_en) m_pc = tick ? 16'd0 : m_pc + 16'd1;
            if (wc && waddr == 2'd1) m_count = wdata;
            else if (match) m_count = 0;
            else if (tick && !(wc && waddr == 2'd3)) m_count = m_count + 32'd1;
            if (match) m_pend = 1;
            else if (wc && waddr == 2'd0 && wdata[2]) m_pend = 0;
            if (wc && waddr == 2'd0) begin
                m_en  = wdata[0];
                m_ie  = wdata[1];
                m_arl = wdata[3];
            end else if (match && !m_arl) begin
                m_en = 0;
            end
            if (wc && waddr == 2'd2) m_cmp = wdata;
            if (wc && waddr == 2'd3) m_presc = wdata[15:0];
        end
        #1;
        check_eq("rd_data", rd_data_o, m_rd_data);
        check_eq("int_flag", {31'd0, int_flag_o}, {31'd0, m_pend & m_ie});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 32'd0, 0, 2'd0);
    endtask

    task automatic wreg(input logic [1:0] idx, input logic [31:0] data);
        step(0, 1, 1, idx, data, 0, 2'd0);
    endtask

    task automatic rreg(input logic [1:0] idx);
        step(0, 0, 0, 2'd0, 32'd0, 1, idx);
        idle(1);
    endtask

    initial begin
        logic found;
        model_reset();

        // Reset held for three cycles, then every register reads zero
        for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd0, 32'd0, 0, 2'd0);
        check_eq("reset_hold", {31'd0, hold_o}, 32'd0);
        for (int a = 0; a < 4; a++) rreg(a[1:0]);

        // Auto-reload: PRESC=1, CMP=3, CTRL=en|ie|arl
        wreg(2'd3, 32'd1);
        wreg(2'd2, 32'd3);
        wreg(2'd0, 32'hB);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 2'd0, 32'd0, i[0], 2'd1);
        rreg(2'd0);

        // One-shot: clear pend, CMP=2, COUNT=0, CTRL=en|ie
        wreg(2'd0, 32'h4);
        wreg(2'd1, 32'd0);
        wreg(2'd2, 32'd2);
        wreg(2'd0, 32'h3);
        idle(10);
        rreg(2'd0);
        rreg(2'd1);
        check_eq("oneshot_irq", {31'd0, int_flag_o}, 32'd1);
        wreg(2'd0, 32'h6);
        check_eq("oneshot_clr", {31'd0, int_flag_o}, 32'd0);

        // Back-to-back reads of different addresses, then a repeated one
        step(0, 0, 0, 2'd0, 32'd0, 1, 2'd1);
        step(0, 0, 0, 2'd0, 32'd0, 1, 2'd2);
        step(0, 0, 0, 2'd0, 32'd0, 1, 2'd2);
        idle(1);

        // Wrap from 0xFFFF_FFFF, match at 5, W1C on the match cycle
        wreg(2'd1, 32'hFFFF_FFFF);
        wreg(2'd2, 32'd5);
        wreg(2'd3, 32'd0);
        wreg(2'd0, 32'hB);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_en && m_pc == m_presc && m_count == m_cmp) begin
                wreg(2'd0, 32'hF);
                found = 1;
            end else begin
                step(0, 0, 0, 2'd0, 32'd0, 1, 2'd1);
            end
        end
        check_eq("w1c_race_seen", {31'd0, found}, 32'd1);
        rreg(2'd0);

        // Reset during a read hold
        step(0, 0, 0, 2'd0, 32'd0, 1, 2'd3);
        step(1, 0, 0, 2'd0, 32'd0, 1, 2'd1);
        step(0, 0, 0, 2'd0, 32'd0, 0, 2'd0);
        check_eq("rst_hold_gone", {31'd0, hold_o}, 32'd0);
        rreg(2'd1);
        rreg(2'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int          r;
            logic        wr, wen, rd, do_rst;
            logic [1:0]  wa, ra;
            logic [31:0] wd;
            r      = $urandom_range(0, 99);
            do_rst = (r < 2);
            wr     = ($urandom_range(0, 99) < 30);
            wen    = ($urandom_range(0, 9) != 0);
            wa     = 2'($urandom_range(0, 3));
            case (wa)
                2'd0:    wd = {$urandom(), 4'h0} | 32'($urandom_range(0, 15));
                2'd1:    wd = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8));
                2'd2:    wd = 32'($urandom_range(0, 8));
                default: wd = {$urandom(), 2'b00} | 32'($urandom_range(0, 3));
            endcase
            rd = ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 2) == 0) ? m_prev_addr : 2'($urandom_range(0, 3));
            step(do_rst, wr, wen, wa, wd, rd, ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
